instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Front-end stage of the MIPS pipeline: owns the PC, fetches instructions from instruction memory over a req/ack handshake, and holds the fetched word in the IF/ID register. It slices the instruction into decode fields; its `imm16_o` output drives the 16→32 sign extender in decode. Stall, redirect and variable-latency memory are absorbed by a small FSM and a one-entry hold buffer, so decode sees a clean valid/stall interface.

## Interface
- `RESET_PC`, 32'h0040_0000: PC loaded on reset (word aligned).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall_i`  in  1  decode cannot accept; IF/ID register holds.
- `redirect_i`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc_i`  in  32  new PC; bits [1:0] ignored (forced 00).
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  fetch address, stable while req high and no ack.
- `imem_ack_i`  in  1  response valid this cycle (may coincide with req).
- `imem_rdata_i`  in  32  instruction word, valid with ack.
- `valid_o`  out  1  IF/ID holds a live instruction.
- `instr_o`  out  32  IF/ID instruction.
- `pc_plus4_o`  out  32  fetch address + 4 of that instruction.
- `opcode_o` 6 [31:26], `rs_o` 5 [25:21], `rt_o` 5 [20:16], `rd_o` 5 [15:11], `shamt_o` 5 [10:6], `funct_o` 6 [5:0], `imm16_o` 16 [15:0], `jaddr_o` 26 [25:0]: combinational slices of `instr_o`.

## Operation
- Registers: `pc`, `req_addr`, FSM state, hold buffer {data, pc+4}, IF/ID {valid, instr, pc+4}.
- States: FETCH, HOLD, DROP. Reset → FETCH, `pc`=`RESET_PC`, `valid_o`=0, `instr_o`=0 (NOP), `pc_plus4_o`=0.
- `imem_req_o` = (FETCH or DROP) and not `reset`; `imem_addr_o` = `pc` in FETCH, `req_addr` in DROP; 0 while reset high.
- IF/ID can accept when `!valid_o || !stall_i`.
- FETCH, ack, no redirect: slot free → load IF/ID, `pc`+=4, stay FETCH; slot blocked → word into hold buffer, `pc`+=4, go HOLD.
- FETCH, no ack, redirect: `req_addr`←`pc`, `pc`←redirect target, go DROP (request must complete at original address).
- FETCH, ack and redirect same cycle: discard word, `pc`←target, stay FETCH.
- HOLD: req low. When IF/ID can accept → buffer into IF/ID, go FETCH. Redirect → discard buffer, `pc`←target, go FETCH.
- DROP: req high at `req_addr`; on ack discard word, go FETCH. Further redirect in DROP overwrites `pc` only.
- Redirect clears `valid_o` next cycle regardless of `stall_i` (redirect beats stall).
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 → 0.
- `reset` mid-transaction: return to reset state next edge; any later ack before a new req is ignored.

## Timing
- Ack in cycle N → `valid_o`/`instr_o` in N+1.
- Zero-wait memory (ack with req): one instruction per cycle sustained.
- Stall release at N → held word in IF/ID at N+1, next request issued N+1 (one bubble).
- Redirect at N → first request to target at N+1 (FETCH) or after pending ack (DROP); target word earliest N+2.

## Structure
- `mips_pkg`: `RESET_PC` default, field bit positions, NOP constant, fetch state enum.
- One sub-module: `if_id_register` (valid/instr/pc+4 with load, hold, flush); FSM, PC and hold buffer in top.

## Test plan
- Reset, zero-wait memory returning addr as data → `imem_addr_o` 0x00400000, 0x00400004, …; `instr_o` = same sequence, one per cycle, `pc_plus4_o` = addr+4.
- Instr 0x2008FFFF fetched → `opcode_o`=0x08, `rs_o`=0, `rt_o`=8, `imm16_o`=0xFFFF.
- `stall_i` high 3 cycles while ack arrives → `instr_o` unchanged, FSM HOLD, req low; after release held word appears, no loss or duplication.
- Memory latency 3, `redirect_i` with 0x00400100 one cycle after req → `imem_addr_o` stays old address until ack, that word never valid, next req 0x00400100.
- Redirect concurrent with ack and `stall_i` → `valid_o`=0 next cycle, next addr = target.
- `RESET_PC`=0xFFFFFFF8, zero-wait → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS front end.
//   RESET_PC_DEFAULT : default fetch address after reset
//   NOP              : instruction word shown in IF/ID after reset
//   field positions  : bit ranges of the decode fields
//   fetch_state_t    : fetch FSM state encoding
//   word_align()     : forces an address to a word boundary
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int JADDR_MSB  = 25;
    localparam int JADDR_LSB  = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register holding {valid, instr, pc+4}.
//   clk, reset     : clock, synchronous active-high reset
//   load           : capture load_instr/load_pc_plus4 as a live instruction
//   flush          : kill the held instruction (wins over load)
//   advance        : decode consumed the current entry this cycle
//   valid/instr/pc_plus4 : registered IF/ID contents
module if_id_register
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic        advance,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc_plus4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            instr    <= NOP;
            pc_plus4 <= 32'd0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            pc_plus4 <= load_pc_plus4;
        end else if (advance) begin
            // Entry consumed with nothing new behind it: leave a bubble.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: MIPS fetch stage. Owns the PC, fetches over a
// req/ack instruction memory port and feeds decode through the IF/ID register.
//   clk, reset           : clock, synchronous active-high reset
//   stall_i              : decode cannot accept a new instruction
//   redirect_i/_pc_i     : taken branch/jump and its target
//   imem_req_o/addr_o    : fetch request and address
//   imem_ack_i/rdata_i   : fetch response and instruction word
//   valid_o/instr_o/pc_plus4_o : IF/ID contents
//   opcode_o..jaddr_o    : decode field slices of instr_o
//
// state    | meaning
// ST_FETCH | request outstanding at pc
// ST_HOLD  | fetched word parked in hold buffer, IF/ID blocked, no request
// ST_DROP  | redirected while waiting; finish request at req_addr, discard it
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic [5:0]  opcode_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  shamt_o,
    output logic [5:0]  funct_o,
    output logic [15:0] imm16_o,
    output logic [25:0] jaddr_o
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_addr;
    logic [31:0]  hold_data;
    logic [31:0]  hold_pc_plus4;

    logic [31:0] pc_seq;
    logic [31:0] target;
    logic        can_accept;
    logic        fetch_hit;
    logic        hold_drain;
    logic        ifid_load;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;

    assign pc_seq     = pc + PC_STEP;
    assign target     = word_align(redirect_pc_i);
    assign can_accept = !valid_o || !stall_i;

    // A word goes straight to IF/ID only when no redirect kills it.
    assign fetch_hit  = (state == ST_FETCH) && imem_ack_i && !redirect_i && can_accept;
    assign hold_drain = (state == ST_HOLD) && !redirect_i && can_accept;

    assign ifid_load     = fetch_hit || hold_drain;
    assign ifid_instr    = hold_drain ? hold_data : imem_rdata_i;
    assign ifid_pc_plus4 = hold_drain ? hold_pc_plus4 : pc_seq;

    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = 32'd0;
        if (!reset) begin
            imem_req_o  = (state == ST_FETCH) || (state == ST_DROP);
            imem_addr_o = (state == ST_DROP) ? req_addr : pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_FETCH;
            pc            <= RESET_PC;
            req_addr      <= 32'd0;
            hold_data     <= NOP;
            hold_pc_plus4 <= 32'd0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack_i && redirect_i) begin
                        pc <= target;
                    end else if (imem_ack_i) begin
                        pc <= pc_seq;
                        if (!can_accept) begin
                            hold_data     <= imem_rdata_i;
                            hold_pc_plus4 <= pc_seq;
                            state         <= ST_HOLD;
                        end
                    end else if (redirect_i) begin
                        // Memory still owes a response for pc; keep its address.
                        req_addr <= pc;
                        pc       <= target;
                        state    <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (redirect_i) begin
                        pc    <= target;
                        state <= ST_FETCH;
                    end else if (can_accept) begin
                        state <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (redirect_i) begin
                        pc <= target;
                    end
                    if (imem_ack_i) begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    if_id_register u_if_id (
        .clk           (clk),
        .reset         (reset),
        .load          (ifid_load),
        .flush         (redirect_i),
        .advance       (!stall_i),
        .load_instr    (ifid_instr),
        .load_pc_plus4 (ifid_pc_plus4),
        .valid         (valid_o),
        .instr         (instr_o),
        .pc_plus4      (pc_plus4_o)
    );

    assign opcode_o = instr_o[OPCODE_MSB:OPCODE_LSB];
    assign rs_o     = instr_o[RS_MSB:RS_LSB];
    assign rt_o     = instr_o[RT_MSB:RT_LSB];
    assign rd_o     = instr_o[RD_MSB:RD_LSB];
    assign shamt_o  = instr_o[SHAMT_MSB:SHAMT_LSB];
    assign funct_o  = instr_o[FUNCT_MSB:FUNCT_LSB];
    assign imm16_o  = instr_o[IMM_MSB:IMM_LSB];
    assign jaddr_o  = instr_o[JADDR_MSB:JADDR_LSB];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] instr, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] jaddr;

    // memory model: zero-wait, or latency 3 (ack in third cycle of req)
    logic        mem_lat = 1'b0;
    logic        ovr = 1'b0;
    logic [31:0] ovr_word = 32'h2008_FFFF;
    logic [1:0]  cnt;

    assign ack   = req && (!mem_lat || cnt == 2'd2);
    assign rdata = ovr ? ovr_word : addr;

    always @(posedge clk) begin
        if (reset)           cnt <= 2'd0;
        else if (req && ack) cnt <= 2'd0;
        else if (req)        cnt <= cnt + 2'd1;
    end

    // second instance: wrap-around PC with zero-wait memory
    logic        req2, ack2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc_plus4_2;
    logic [5:0]  opcode2, funct2;
    logic [4:0]  rs2, rt2, rd2, shamt2;
    logic [15:0] imm16_2;
    logic [25:0] jaddr2;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = 32'd0;

    assign ack2   = req2;
    assign rdata2 = addr2;

    instruction_fetch_stage dut (
        .clk(clk), .reset(reset), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_rdata_i(rdata), .valid_o(valid),
        .instr_o(instr), .pc_plus4_o(pc_plus4), .opcode_o(opcode), .rs_o(rs),
        .rt_o(rt), .rd_o(rd), .shamt_o(shamt), .funct_o(funct),
        .imm16_o(imm16), .jaddr_o(jaddr)
    );

    instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .stall_i(zero_bit), .redirect_i(zero_bit),
        .redirect_pc_i(zero_word), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_ack_i(ack2), .imem_rdata_i(rdata2), .valid_o(valid2),
        .instr_o(instr2), .pc_plus4_o(pc_plus4_2), .opcode_o(opcode2), .rs_o(rs2),
        .rt_o(rt2), .rd_o(rd2), .shamt_o(shamt2), .funct_o(funct2),
        .imm16_o(imm16_2), .jaddr_o(jaddr2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        reset = 1'b1;
        tick();
        tick();
        check("rst_valid", valid, 0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc4", pc_plus4, 32'd0);
        check("rst_req", req, 0);
        check("rst_addr", addr, 32'd0);

        // zero-wait streaming
        reset = 1'b0;
        #1;
        check("first_req", req, 1);
        check("first_addr", addr, 32'h0040_0000);
        check("wrap_addr0", addr2, 32'hFFFF_FFF8);
        tick();
        check("s0_valid", valid, 1);
        check("s0_instr", instr, 32'h0040_0000);
        check("s0_pc4", pc_plus4, 32'h0040_0004);
        check("s0_addr", addr, 32'h0040_0004);
        check("wrap_addr1", addr2, 32'hFFFF_FFFC);
        check("wrap_instr0", instr2, 32'hFFFF_FFF8);
        tick();
        check("wrap_addr2", addr2, 32'h0000_0000);
        check("wrap_instr1", instr2, 32'hFFFF_FFFC);
        check("wrap_pc4_1", pc_plus4_2, 32'h0000_0000);
        check("s1_instr", instr, 32'h0040_0004);
        check("s1_pc4", pc_plus4, 32'h0040_0008);
        for (int i = 2; i < 4; i++) begin
            tick();
            check("sn_valid", valid, 1);
            check("sn_instr", instr, 32'h0040_0000 + 32'(4 * i));
            check("sn_pc4", pc_plus4, 32'h0040_0004 + 32'(4 * i));
        end

        // decode field slicing
        ovr = 1'b1;
        tick();
        ovr = 1'b0;
        check("fld_instr", instr, 32'h2008_FFFF);
        check("fld_opcode", opcode, 32'h08);
        check("fld_rs", rs, 32'h0);
        check("fld_rt", rt, 32'h8);
        check("fld_rd", rd, 32'h1F);
        check("fld_funct", funct, 32'h3F);
        check("fld_imm16", imm16, 32'hFFFF);
        check("fld_jaddr", jaddr, 32'h008_FFFF);
        check("fld_pc4", pc_plus4, 32'h0040_0014);

        // stall while ack arrives: word 0x00400014 parks in hold buffer
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_valid", valid, 1);
            check("stl_instr", instr, 32'h2008_FFFF);
            check("stl_req", req, 0);
        end
        stall = 1'b0;
        tick();
        check("rel_instr", instr, 32'h0040_0014);
        check("rel_pc4", pc_plus4, 32'h0040_0018);
        check("rel_req", req, 1);
        check("rel_addr", addr, 32'h0040_0018);
        tick();
        check("rel_next", instr, 32'h0040_0018);

        // latency 3, redirect one cycle after request
        mem_lat = 1'b1;
        tick();
        check("lat_bubble", valid, 0);
        check("lat_addr", addr, 32'h0040_001C);
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0103;
        tick();
        redirect = 1'b0;
        check("drop_req", req, 1);
        check("drop_addr", addr, 32'h0040_001C);
        check("drop_valid", valid, 0);
        tick();
        check("drop_done_valid", valid, 0);
        check("tgt_addr", addr, 32'h0040_0100);
        tick();
        check("tgt_wait1", valid, 0);
        check("tgt_addr_stable", addr, 32'h0040_0100);
        tick();
        check("tgt_wait2", valid, 0);
        tick();
        check("tgt_valid", valid, 1);
        check("tgt_instr", instr, 32'h0040_0100);
        check("tgt_pc4", pc_plus4, 32'h0040_0104);

        // redirect + ack + stall in the same cycle
        mem_lat     = 1'b0;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0200;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("rsa_valid", valid, 0);
        check("rsa_addr", addr, 32'h0040_0200);
        tick();
        check("rsa_instr", instr, 32'h0040_0200);
        check("rsa_valid2", valid, 1);

        // reset mid-stream
        reset = 1'b1;
        tick();
        check("mid_rst_valid", valid, 0);
        check("mid_rst_req", req, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_addr", addr, 32'h0040_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
